// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-port SRAM arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 14;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} arb_state_t;

    typedef logic port_t;
    localparam port_t PORT0 = 1'b0;
    localparam port_t PORT1 = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester ports plus SRAM handshake, bundled for the arbiter.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              p0_req;
    logic [ADDR_W-1:0] p0_addr;
    logic              p0_done;
    logic              p0_err;
    logic [DATA_W-1:0] p0_rdata;
    logic              p0_gnt;

    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_done;
    logic              p1_err;
    logic [DATA_W-1:0] p1_rdata;
    logic              p1_gnt;

    logic              sram_re;
    logic              sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic              sram_wdata_oe;
    logic [DATA_W-1:0] sram_rdata;
    logic              mem_resp;

    // Arbiter side
    modport slave (
        input  p0_req, p0_addr, p1_req, p1_we, p1_addr, p1_wdata, sram_rdata, mem_resp,
        output p0_done, p0_err, p0_rdata, p0_gnt, p1_done, p1_err, p1_rdata, p1_gnt,
        output sram_re, sram_we, sram_addr, sram_wdata, sram_wdata_oe
    );

    // Requesters and SRAM side
    modport master (
        output p0_req, p0_addr, p1_req, p1_we, p1_addr, p1_wdata, sram_rdata, mem_resp,
        input  p0_done, p0_err, p0_rdata, p0_gnt, p1_done, p1_err, p1_rdata, p1_gnt,
        input  sram_re, sram_we, sram_addr, sram_wdata, sram_wdata_oe
    );

endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer sharing one SRAM between fetch (port 0) and
// load/store (port 1), with a watchdog that aborts unacknowledged transfers.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);

    localparam int               CNT_W   = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    arb_state_t        state_reg, state_next;
    port_t             last_reg, last_next;
    port_t             owner_reg, owner_next;
    port_t             pick;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              re_reg, re_next;
    logic              we_reg, we_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic [1:0]        gnt_reg, gnt_next;
    logic [1:0]        done_reg, done_next;
    logic [1:0]        err_reg, err_next;
    logic [DATA_W-1:0] rdata_reg [2];
    logic [DATA_W-1:0] rdata_next [2];
    logic [1:0]        req;

    assign req = {bus.p1_req, bus.p0_req};

    // On a tie the port that was not granted last wins.
    always_comb begin
        if (req == 2'b11) begin
            pick = ~last_reg;
        end else if (req[1]) begin
            pick = PORT1;
        end else begin
            pick = PORT0;
        end
    end

    always_comb begin
        state_next = state_reg;
        last_next  = last_reg;
        owner_next = owner_reg;
        cnt_next   = cnt_reg;
        re_next    = re_reg;
        we_next    = we_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        gnt_next   = gnt_reg;
        done_next  = '0;
        err_next   = '0;
        rdata_next = rdata_reg;

        case (state_reg)
            IDLE: begin
                if (|req) begin
                    state_next     = BUSY;
                    last_next      = pick;
                    owner_next     = pick;
                    cnt_next       = '0;
                    gnt_next       = '0;
                    gnt_next[pick] = 1'b1;
                    if (pick == PORT1) begin
                        addr_next  = bus.p1_addr;
                        wdata_next = bus.p1_wdata;
                        we_next    = bus.p1_we;
                    end else begin
                        addr_next  = bus.p0_addr;
                        wdata_next = '0;
                        we_next    = 1'b0;
                    end
                    re_next = ~we_next;
                end
            end

            BUSY: begin
                // A response in the expiry cycle still counts as success.
                if (bus.mem_resp || (cnt_reg == CNT_MAX)) begin
                    state_next           = DONE;
                    re_next              = 1'b0;
                    we_next              = 1'b0;
                    gnt_next             = '0;
                    done_next[owner_reg] = 1'b1;
                    if (!bus.mem_resp) begin
                        err_next[owner_reg]   = 1'b1;
                        rdata_next[owner_reg] = '0;
                    end else if (!we_reg) begin
                        rdata_next[owner_reg] = bus.sram_rdata;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            last_reg     <= PORT0;
            owner_reg    <= PORT0;
            cnt_reg      <= '0;
            re_reg       <= 1'b0;
            we_reg       <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            gnt_reg      <= '0;
            done_reg     <= '0;
            err_reg      <= '0;
            rdata_reg[0] <= '0;
            rdata_reg[1] <= '0;
        end else begin
            state_reg <= state_next;
            last_reg  <= last_next;
            owner_reg <= owner_next;
            cnt_reg   <= cnt_next;
            re_reg    <= re_next;
            we_reg    <= we_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            gnt_reg   <= gnt_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
            rdata_reg <= rdata_next;
        end
    end

    assign bus.p0_gnt        = gnt_reg[0];
    assign bus.p0_done       = done_reg[0];
    assign bus.p0_err        = err_reg[0];
    assign bus.p0_rdata      = rdata_reg[0];
    assign bus.p1_gnt        = gnt_reg[1];
    assign bus.p1_done       = done_reg[1];
    assign bus.p1_err        = err_reg[1];
    assign bus.p1_rdata      = rdata_reg[1];
    assign bus.sram_re       = re_reg;
    assign bus.sram_we       = we_reg;
    assign bus.sram_addr     = addr_reg;
    assign bus.sram_wdata    = wdata_reg;
    assign bus.sram_wdata_oe = we_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction table plus arbitration,
// reset and idle-response sequences.
module tb_mem_arbiter;

    localparam int AW      = 14;
    localparam int DW      = 16;
    localparam int TIMEOUT = 8;

    typedef struct {
        int          port;
        bit          we;
        logic [13:0] addr;
        logic [15:0] wdata;
        int          lat;        // 0 = SRAM never responds
        bit          exp_err;
        logic [15:0] exp_rdata;
        int          exp_busy;
    } vec_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    logic [15:0] mem_model [256];
    vec_t vecs [9];

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic done_of(input int p);
        return (p == 1) ? bus.p1_done : bus.p0_done;
    endfunction

    function automatic logic err_of(input int p);
        return (p == 1) ? bus.p1_err : bus.p0_err;
    endfunction

    function automatic logic gnt_of(input int p);
        return (p == 1) ? bus.p1_gnt : bus.p0_gnt;
    endfunction

    function automatic logic [15:0] rdata_of(input int p);
        return (p == 1) ? bus.p1_rdata : bus.p0_rdata;
    endfunction

    task automatic chk_all_zero(input string name);
        chk(name, 32'({bus.p0_done, bus.p0_err, bus.p0_gnt, bus.p1_done, bus.p1_err,
                       bus.p1_gnt, bus.sram_re, bus.sram_we, bus.sram_wdata_oe}), 32'd0);
        chk(name, 32'(bus.p0_rdata), 32'd0);
        chk(name, 32'(bus.p1_rdata), 32'd0);
        chk(name, 32'(bus.sram_addr), 32'd0);
        chk(name, 32'(bus.sram_wdata), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_grant(output int which, output int cycles);
        which  = -1;
        cycles = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.p0_gnt || bus.p1_gnt) begin
                which  = bus.p1_gnt ? 1 : 0;
                cycles = k;
                break;
            end
        end
        if (which < 0) begin
            total++;
            bad++;
            $display("FAIL grant_wait: no grant within 20 cycles");
        end
    endtask

    // Starts at a negedge with the arbiter in IDLE, ends at the negedge after the done pulse.
    task automatic run_txn(input vec_t v, input int idx);
        bit got;
        int cyc;
        if (v.port == 1) begin
            bus.p1_req   = 1'b1;
            bus.p1_we    = v.we;
            bus.p1_addr  = v.addr;
            bus.p1_wdata = v.wdata;
        end else begin
            bus.p0_req  = 1'b1;
            bus.p0_addr = v.addr;
        end
        @(negedge clk);
        chk($sformatf("v%0d grant", idx), 32'(gnt_of(v.port)), 32'd1);
        bus.p0_req   = 1'b0;
        bus.p1_req   = 1'b0;
        bus.p0_addr  = ~v.addr;
        bus.p1_addr  = ~v.addr;
        bus.p1_wdata = ~v.wdata;
        bus.p1_we    = ~v.we;
        got = 1'b0;
        cyc = 0;
        for (int k = 1; k <= TIMEOUT + 4; k++) begin
            chk($sformatf("v%0d sram_addr", idx), 32'(bus.sram_addr), 32'(v.addr));
            chk($sformatf("v%0d sram_re", idx), 32'(bus.sram_re), 32'(!v.we));
            chk($sformatf("v%0d sram_we", idx), 32'(bus.sram_we), 32'(v.we));
            chk($sformatf("v%0d wdata_oe", idx), 32'(bus.sram_wdata_oe), 32'(v.we));
            if (v.we) chk($sformatf("v%0d sram_wdata", idx), 32'(bus.sram_wdata), 32'(v.wdata));
            if (k == v.lat) begin
                bus.mem_resp = 1'b1;
                if (v.we) mem_model[bus.sram_addr[7:0]] = bus.sram_wdata;
                else      bus.sram_rdata = mem_model[bus.sram_addr[7:0]];
            end
            @(negedge clk);
            bus.mem_resp   = 1'b0;
            bus.sram_rdata = 16'hDEAD;
            if (done_of(v.port)) begin
                got = 1'b1;
                cyc = k;
                break;
            end
        end
        chk($sformatf("v%0d done_seen", idx), 32'(got), 32'd1);
        if (got) begin
            chk($sformatf("v%0d busy_cycles", idx), 32'(cyc), 32'(v.exp_busy));
            chk($sformatf("v%0d err", idx), 32'(err_of(v.port)), 32'(v.exp_err));
            chk($sformatf("v%0d rdata", idx), 32'(rdata_of(v.port)), 32'(v.exp_rdata));
            chk($sformatf("v%0d release", idx),
                32'({bus.p0_gnt, bus.p1_gnt, bus.sram_re, bus.sram_we}), 32'd0);
            chk($sformatf("v%0d other_done", idx), 32'(done_of(1 - v.port)), 32'd0);
        end
        @(negedge clk);
        chk($sformatf("v%0d done_pulse", idx), 32'(done_of(v.port)), 32'd0);
        chk($sformatf("v%0d err_pulse", idx), 32'(err_of(v.port)), 32'd0);
    endtask

    task automatic serve_tie(input int i);
        int which;
        int cyc;
        wait_grant(which, cyc);
        chk($sformatf("tie%0d winner", i), 32'(which), (i % 2 == 0) ? 32'd1 : 32'd0);
        chk($sformatf("tie%0d spacing", i), 32'(cyc), (i == 0) ? 32'd1 : 32'd2);
        bus.mem_resp = 1'b1;
        @(negedge clk);
        bus.mem_resp = 1'b0;
        chk($sformatf("tie%0d done", i), 32'((which == 1) ? bus.p1_done : bus.p0_done), 32'd1);
    endtask

    initial begin
        int which;
        int cyc;
        total = 0;
        bad   = 0;
        for (int i = 0; i < 256; i++) mem_model[i] = 16'h0000;

        //        port we    addr      wdata     lat err   rdata     busy
        vecs[0] = '{1, 1'b1, 14'h0123, 16'hBEEF, 3, 1'b0, 16'h0000, 3};
        vecs[1] = '{1, 1'b0, 14'h0123, 16'h0000, 2, 1'b0, 16'hBEEF, 2};
        vecs[2] = '{0, 1'b0, 14'h0123, 16'h0000, 1, 1'b0, 16'hBEEF, 1};
        vecs[3] = '{0, 1'b0, 14'h0045, 16'h0000, 0, 1'b1, 16'h0000, 8};
        vecs[4] = '{0, 1'b0, 14'h0123, 16'h0000, 8, 1'b0, 16'hBEEF, 8};
        vecs[5] = '{1, 1'b1, 14'h0045, 16'h1234, 1, 1'b0, 16'hBEEF, 1};
        vecs[6] = '{1, 1'b0, 14'h0045, 16'h0000, 5, 1'b0, 16'h1234, 5};
        vecs[7] = '{1, 1'b1, 14'h0045, 16'h5555, 0, 1'b1, 16'h0000, 8};
        vecs[8] = '{1, 1'b0, 14'h0045, 16'h0000, 1, 1'b0, 16'h1234, 1};

        reset          = 1'b1;
        bus.p0_req     = 1'b0;
        bus.p0_addr    = '0;
        bus.p1_req     = 1'b0;
        bus.p1_we      = 1'b0;
        bus.p1_addr    = '0;
        bus.p1_wdata   = '0;
        bus.sram_rdata = 16'hDEAD;
        bus.mem_resp   = 1'b0;

        repeat (2) @(negedge clk);
        chk_all_zero("reset_state");
        reset = 1'b0;

        // Simultaneous requests straight out of reset: 1,0,1,0
        bus.p0_req  = 1'b1;
        bus.p1_req  = 1'b1;
        bus.p0_addr = 14'h0010;
        bus.p1_addr = 14'h0020;
        for (int i = 0; i < 4; i++) serve_tie(i);
        bus.p0_req = 1'b0;
        bus.p1_req = 1'b0;

        do_reset();
        for (int i = 0; i < 9; i++) run_txn(vecs[i], i);

        // Reset in the second BUSY cycle of a load
        bus.p1_req  = 1'b1;
        bus.p1_we   = 1'b0;
        bus.p1_addr = 14'h0045;
        @(negedge clk);
        chk("rst_mid grant", 32'(bus.p1_gnt), 32'd1);
        bus.p1_req = 1'b0;
        @(negedge clk);
        chk("rst_mid busy2", 32'(bus.sram_re), 32'd1);
        #2 reset = 1'b1;
        #1 chk_all_zero("rst_mid async");
        bus.mem_resp = 1'b1;
        @(negedge clk);
        bus.mem_resp = 1'b0;
        reset        = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_mid no_done", 32'({bus.p0_done, bus.p1_done, bus.p0_gnt, bus.p1_gnt}), 32'd0);
        end
        bus.p0_req  = 1'b1;
        bus.p0_addr = 14'h0123;
        @(negedge clk);
        chk("post_rst grant", 32'(bus.p0_gnt), 32'd1);
        bus.p0_req     = 1'b0;
        bus.sram_rdata = 16'h7E57;
        bus.mem_resp   = 1'b1;
        @(negedge clk);
        bus.mem_resp   = 1'b0;
        bus.sram_rdata = 16'hDEAD;
        chk("post_rst done", 32'(bus.p0_done), 32'd1);
        chk("post_rst rdata", 32'(bus.p0_rdata), 32'h7E57);
        @(negedge clk);

        // Stray responses while idle
        bus.mem_resp = 1'b1;
        repeat (2) @(negedge clk);
        bus.mem_resp = 1'b0;
        chk("idle_resp outputs", 32'({bus.p0_done, bus.p1_done, bus.p0_gnt, bus.p1_gnt,
                                      bus.sram_re, bus.sram_we}), 32'd0);
        chk("idle_resp rdata", 32'(bus.p0_rdata), 32'h7E57);

        // Port 0 held continuously, stray response during each DONE cycle
        bus.p0_req  = 1'b1;
        bus.p0_addr = 14'h0077;
        for (int i = 0; i < 3; i++) begin
            wait_grant(which, cyc);
            chk($sformatf("held%0d winner", i), 32'(which), 32'd0);
            chk($sformatf("held%0d spacing", i), 32'(cyc), 32'd1);
            chk($sformatf("held%0d addr", i), 32'(bus.sram_addr), 32'h0077);
            bus.sram_rdata = 16'(16'h0A00 + i);
            bus.mem_resp   = 1'b1;
            @(negedge clk);
            bus.mem_resp   = 1'b0;
            bus.sram_rdata = 16'hFFFF;
            chk($sformatf("held%0d done", i), 32'(bus.p0_done), 32'd1);
            chk($sformatf("held%0d rdata", i), 32'(bus.p0_rdata), 32'(16'h0A00 + i));
            bus.mem_resp = 1'b1;
            @(negedge clk);
            bus.mem_resp = 1'b0;
            chk($sformatf("held%0d turnaround", i),
                32'({bus.p0_done, bus.p0_err, bus.p0_gnt}), 32'd0);
            chk($sformatf("held%0d rdata_hold", i), 32'(bus.p0_rdata), 32'(16'h0A00 + i));
        end
        bus.p0_req = 1'b0;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer in front of the single-port SRAM. It shares the SRAM between the instruction-fetch port (port 0, read-only) and the load/store data port (port 1, read/write). It applies round-robin arbitration, holds the SRAM `re`/`we`/`addr` handshake until `mem_resp`, and returns read data with a one-cycle done pulse. A watchdog aborts any transfer the SRAM never acknowledges.

## Interface
- `ADDR_W`, default 14: SRAM word-address width.
- `DATA_W`, default 16: SRAM data width.
- `TIMEOUT`, default 64: maximum cycles in BUSY without `mem_resp` before abort. Must be at least 2.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `p0_req` in 1: fetch read request, level.
- `p0_addr` in ADDR_W: fetch address.
- `p0_done` out 1: one-cycle completion pulse.
- `p0_err` out 1: timeout flag, valid with `p0_done`.
- `p0_rdata` out DATA_W: read data, valid with `p0_done`; held until the next port-0 done.
- `p0_gnt` out 1: high while port 0 owns the SRAM.
- `p1_req` in 1: data request, level.
- `p1_we` in 1: 1 = store, 0 = load.
- `p1_addr` in ADDR_W: data address.
- `p1_wdata` in DATA_W: store data.
- `p1_done`, `p1_err`, `p1_rdata`, `p1_gnt` out: same meaning as the port-0 signals, for port 1.
- `sram_re` out 1: SRAM read request.
- `sram_we` out 1: SRAM write request.
- `sram_addr` out ADDR_W: SRAM address.
- `sram_wdata` out DATA_W: SRAM write data.
- `sram_wdata_oe` out 1: write-data drive enable for the top-level tristate. Equals `sram_we`.
- `sram_rdata` in DATA_W: SRAM read data.
- `mem_resp` in 1: SRAM acknowledge, one-cycle pulse.

## Operation
- FSM states:
  - IDLE: no transfer; the arbiter samples the requests here.
  - BUSY: a transfer is in flight on the SRAM.
  - DONE: one-cycle turnaround after completion.
- IDLE transitions:
  - Any `pN_req` high moves to BUSY.
  - The winner's `addr`, `we` and `wdata` are captured into registers. Port 0 always captures `we = 0`.
  - The winner's `pN_gnt` and `sram_re` (or `sram_we`) assert in the next cycle.
- Round-robin: `last` is one register bit.
  - When both ports request, the port that is not `last` wins.
  - `last` updates on every grant.
  - Reset value of `last` is 0, so port 1 wins the first tie.
- BUSY transitions:
  - SRAM outputs are held constant.
  - `mem_resp` high moves to DONE. `pN_done` pulses and, on a read, `pN_rdata` captures `sram_rdata`.
  - If the timeout counter reaches TIMEOUT-1 with `mem_resp` low, the FSM moves to DONE with `pN_err` = 1 and `pN_rdata` = 0.
- DONE: all SRAM requests and grants are low. The FSM returns to IDLE unconditionally.
- Request fields are used only at grant. A requester may change `addr`/`wdata` after its `gnt` rises.
- Dropping `req` mid-transfer does not cancel the transfer; `done` still pulses.
- `req` still high in IDLE after `done` is treated as a new request.
- `mem_resp` outside BUSY is ignored.
- `mem_resp` in the same cycle as timeout expiry counts as a normal completion (`err` = 0).

## Timing
- All outputs are registered.
- Reset values:
  - state = IDLE, `last` = 0, counter = 0.
  - Every output is 0, including `rdata`.
- Reset asserted mid-transfer:
  - All outputs drop to 0 immediately (asynchronous).
  - The transfer is lost and no `done` is issued.
- Grant latency: `req` sampled at edge N → `gnt` and `sram_re`/`sram_we` high from edge N+1.
- `mem_resp` sampled at edge M gives:
  - `sram_re`/`sram_we` low at M+1;
  - `done` high for the single cycle starting at M+1;
  - `rdata` valid from M+1;
  - next grant no earlier than edge M+2.
- Minimum occupancy per transfer is BUSY 1 cycle plus DONE 1 cycle. Back-to-back throughput is one transfer per (SRAM latency + 2) cycles.
- Timeout counter:
  - clears on entry to BUSY and increments each BUSY cycle;
  - abort is taken at the edge where count = TIMEOUT-1, i.e. after TIMEOUT cycles in BUSY;
  - width is $clog2(TIMEOUT); no wrap occurs.

## Structure
- Package `mem_arb_pkg`:
  - `arb_state_t` enum {IDLE, BUSY, DONE};
  - `port_t` (1-bit port index);
  - constants for the default ADDR_W and DATA_W.
- Single module; no sub-module required.
- Round-robin pick and watchdog stay inline as small always_comb/always_ff blocks.
- Tristate of `sram_wdata` onto the SRAM's inout data bus is done at the top level using `sram_wdata_oe`.

## Test plan
- Port 1 store, `addr` 0x0123, `wdata` 0xBEEF, SRAM responds after 3 cycles → `sram_we` high 3 cycles, `p1_done` single pulse, `p1_err` 0. A following load of 0x0123 returns `p1_rdata` 0xBEEF.
- Both `req` high at the same edge immediately after reset → port 1 granted first, port 0 second. Repeated ties alternate grants 1,0,1,0.
- Port 0 fetch with `mem_resp` never asserted, TIMEOUT = 8 → `p0_done` and `p0_err` pulse exactly 8 cycles after grant, `p0_rdata` = 0, FSM back in IDLE.
- `mem_resp` coincident with timeout expiry → `err` = 0 and `rdata` captured.
- Reset asserted in the second BUSY cycle → all outputs 0 asynchronously and no `done`. The first request after reset release is granted in one cycle.
- `p0_req` held high continuously with `p1_req` idle → grants are spaced by DONE turnaround (gap of one cycle), and `mem_resp` pulses in IDLE do not disturb the outputs.
